// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single shared Memory.
// One port owns the Memory at a time; every grant returns through IDLE before the next.
module mem_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              c0_rd,
   input  logic              c0_wr,
   input  logic [ADDR_W-1:0] c0_addr,
   input  logic [DATA_W-1:0] c0_din,
   input  logic              c1_rd,
   input  logic              c1_wr,
   input  logic [ADDR_W-1:0] c1_addr,
   input  logic [DATA_W-1:0] c1_din,
   output logic [DATA_W-1:0] c0_dout,
   output logic [DATA_W-1:0] c1_dout,
   output logic              c0_done,
   output logic              c1_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_dout,
   input  logic              mem_done,
   output logic [1:0]        grant,
   output logic [7:0]        c0_cnt,
   output logic [7:0]        c1_cnt
);

   typedef enum logic [2:0] {
      IDLE  = 3'b001,
      BUSY0 = 3'b010,
      BUSY1 = 3'b100
   } state_t;

   state_t     state_q, state_d;
   logic       last_q, last_d;
   logic [7:0] c0_cnt_q, c0_cnt_d;
   logic [7:0] c1_cnt_q, c1_cnt_d;
   logic       req0, req1;

   assign req0 = c0_rd | c0_wr;
   assign req1 = c1_rd | c1_wr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         c0_cnt_q <= 8'd0;
         c1_cnt_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         c0_cnt_q <= c0_cnt_d;
         c1_cnt_q <= c1_cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      c0_cnt_d = c0_cnt_q;
      c1_cnt_d = c1_cnt_q;
      unique case (state_q)
         IDLE: begin
            // On a tie the port that did not finish last wins.
            if (req0 && req1)  state_d = last_q ? BUSY0 : BUSY1;
            else if (req0)     state_d = BUSY0;
            else if (req1)     state_d = BUSY1;
         end
         BUSY0: begin
            if (mem_done) begin
               state_d  = IDLE;
               last_d   = 1'b0;
               c0_cnt_d = c0_cnt_q + 8'd1;
            end else if (!req0) begin
               state_d  = IDLE;
            end
         end
         BUSY1: begin
            if (mem_done) begin
               state_d  = IDLE;
               last_d   = 1'b1;
               c1_cnt_d = c1_cnt_q + 8'd1;
            end else if (!req1) begin
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_addr = '0;
      mem_din  = '0;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      grant    = 2'b00;
      c0_done  = 1'b0;
      c1_done  = 1'b0;
      unique case (state_q)
         BUSY0: begin
            mem_addr = c0_addr;
            mem_din  = c0_din;
            mem_wr   = c0_wr;
            mem_rd   = c0_rd & ~c0_wr;
            grant    = 2'b01;
            c0_done  = mem_done & ~rst;
         end
         BUSY1: begin
            mem_addr = c1_addr;
            mem_din  = c1_din;
            mem_wr   = c1_wr;
            mem_rd   = c1_rd & ~c1_wr;
            grant    = 2'b10;
            c1_done  = mem_done & ~rst;
         end
         default: ;
      endcase
   end

   assign c0_dout = mem_dout;
   assign c1_dout = mem_dout;
   assign c0_cnt  = c0_cnt_q;
   assign c1_cnt  = c1_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then randomized traffic, all checked
// against a transaction-level owner/counter/memory model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        c0_rd, c0_wr, c1_rd, c1_wr;
   logic [4:0]  c0_addr, c1_addr;
   logic [15:0] c0_din, c1_din;
   logic [15:0] c0_dout, c1_dout;
   logic        c0_done, c1_done;
   logic [4:0]  mem_addr;
   logic [15:0] mem_din;
   logic        mem_rd, mem_wr;
   logic [15:0] mem_dout;
   logic        mem_done;
   logic [1:0]  grant;
   logic [7:0]  c0_cnt, c1_cnt;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(5), .DATA_W(16)) dut (
      .clk(clk), .rst(rst),
      .c0_rd(c0_rd), .c0_wr(c0_wr), .c0_addr(c0_addr), .c0_din(c0_din),
      .c1_rd(c1_rd), .c1_wr(c1_wr), .c1_addr(c1_addr), .c1_din(c1_din),
      .c0_dout(c0_dout), .c1_dout(c1_dout),
      .c0_done(c0_done), .c1_done(c1_done),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_dout(mem_dout), .mem_done(mem_done),
      .grant(grant), .c0_cnt(c0_cnt), .c1_cnt(c1_cnt)
   );

   // Shared Memory emulation: asynchronous read, write committed on the done edge.
   logic [15:0] mem_arr [32] = '{default: '0};
   assign mem_dout = mem_arr[mem_addr];
   always @(posedge clk) if (mem_wr && mem_done) mem_arr[mem_addr] <= mem_din;

   // Reference model: who owns the Memory, round-robin memory, completions, contents.
   int          owner = -1;
   bit          last = 1'b1;
   int          cnt0 = 0, cnt1 = 0;
   logic [15:0] ref_mem [32] = '{default: '0};

   int n_chk = 0, n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input bit do_chk);
      bit          r0, r1, e_rd, e_wr, d0, d1;
      logic [4:0]  ea;
      logic [15:0] ed;
      logic [1:0]  eg;
      @(negedge clk);
      r0 = c0_rd | c0_wr;
      r1 = c1_rd | c1_wr;
      eg = 2'b00; e_rd = 0; e_wr = 0; ea = '0; ed = '0; d0 = 0; d1 = 0;
      if (owner == 0) begin
         eg = 2'b01; ea = c0_addr; ed = c0_din; e_wr = c0_wr; e_rd = c0_rd && !c0_wr;
         d0 = mem_done && !rst;
      end else if (owner == 1) begin
         eg = 2'b10; ea = c1_addr; ed = c1_din; e_wr = c1_wr; e_rd = c1_rd && !c1_wr;
         d1 = mem_done && !rst;
      end
      if (do_chk) begin
         check_eq("grant", grant, eg);
         check_eq("mem_rd", mem_rd, e_rd);
         check_eq("mem_wr", mem_wr, e_wr);
         check_eq("mem_addr", mem_addr, ea);
         check_eq("mem_din", mem_din, ed);
         check_eq("c0_done", c0_done, d0);
         check_eq("c1_done", c1_done, d1);
         check_eq("c0_cnt", c0_cnt, cnt0);
         check_eq("c1_cnt", c1_cnt, cnt1);
         check_eq("c0_dout", c0_dout, ref_mem[ea]);
         check_eq("c1_dout", c1_dout, ref_mem[ea]);
      end
      if (e_wr && mem_done) ref_mem[ea] = ed;
      if (rst) begin
         owner = -1; last = 1'b1; cnt0 = 0; cnt1 = 0;
      end else if (owner == -1) begin
         if (r0 && r1)  owner = last ? 0 : 1;
         else if (r0)   owner = 0;
         else if (r1)   owner = 1;
      end else if (mem_done) begin
         if (owner == 0) cnt0 = (cnt0 + 1) % 256;
         else            cnt1 = (cnt1 + 1) % 256;
         last  = (owner == 1);
         owner = -1;
      end else if (!((owner == 0) ? r0 : r1)) begin
         owner = -1;
      end
      @(posedge clk);
      #1;
      // A requester releases its request once it has seen its done pulse.
      if (d0) begin c0_rd = 0; c0_wr = 0; end
      if (d1) begin c1_rd = 0; c1_wr = 0; end
   endtask

   initial begin
      logic [1:0] kind;
      rst = 1; mem_done = 0;
      c0_rd = 0; c0_wr = 0; c0_addr = '0; c0_din = '0;
      c1_rd = 0; c1_wr = 0; c1_addr = '0; c1_din = '0;
      @(posedge clk); #1;
      step(0);
      step(1);
      rst = 0;

      // Port-0 write then port-1 read-back of the same word.
      c0_wr = 1; c0_addr = 5'd4; c0_din = 16'h0C03;
      step(1);
      check_eq("w_memwr_lat1", mem_wr, 1'b1);
      step(1);
      mem_done = 1; #1;
      check_eq("w_c0_done", c0_done, 1'b1);
      step(1);
      mem_done = 0;
      check_eq("w_c0_cnt", c0_cnt, 8'd1);
      step(1);
      c1_rd = 1; c1_addr = 5'd4;
      step(1);
      check_eq("r_grant10", grant, 2'b10);
      mem_done = 1; #1;
      check_eq("r_c1_done", c1_done, 1'b1);
      check_eq("r_c1_dout", c1_dout, 16'h0C03);
      step(1);
      mem_done = 0;
      check_eq("r_c1_cnt", c1_cnt, 8'd1);
      step(1);

      // Ties: port 0 first after reset, then port 1, then port 0 again.
      rst = 1; step(1); rst = 0;
      c0_rd = 1; c0_addr = 5'd1; c1_rd = 1; c1_addr = 5'd2; mem_done = 1;
      step(1);
      check_eq("tie1_grant", grant, 2'b01);
      step(1);
      check_eq("tie1_idle", grant, 2'b00);
      step(1);
      check_eq("tie1_second", grant, 2'b10);
      step(1);
      c0_rd = 1; c1_rd = 1;
      step(1);
      check_eq("tie2_grant", grant, 2'b01);
      step(1); step(1); step(1);
      mem_done = 0;
      step(1);

      // 256 back-to-back port-0 reads wrap the counter.
      rst = 1; step(1); rst = 0;
      mem_done = 1;
      for (int i = 0; i < 256; i++) begin
         c0_rd = 1; c0_addr = 5'(i);
         step(1);
         step(1);
      end
      mem_done = 0;
      check_eq("wrap_c0_cnt", c0_cnt, 8'd0);
      check_eq("wrap_c1_cnt", c1_cnt, 8'd0);

      // Reset in the middle of a port-1 transaction.
      c1_rd = 1; c1_addr = 5'd3;
      step(1); step(1);
      rst = 1; mem_done = 1; #1;
      check_eq("rstmid_c1_done", c1_done, 1'b0);
      step(1);
      rst = 0; mem_done = 0;
      check_eq("rstmid_mem_rd", mem_rd, 1'b0);
      check_eq("rstmid_grant", grant, 2'b00);
      check_eq("rstmid_c1_cnt", c1_cnt, 8'd0);
      c1_rd = 0;
      step(1);

      // Port-0 abort hands over to a pending port-1 request.
      c0_rd = 1; c0_addr = 5'd5;
      step(1);
      c1_rd = 1; c1_addr = 5'd6;
      step(1);
      c0_rd = 0;
      step(1);
      check_eq("abort_idle", grant, 2'b00);
      check_eq("abort_c0_cnt", c0_cnt, 8'd0);
      step(1);
      check_eq("abort_p1_grant", grant, 2'b10);
      mem_done = 1; step(1);
      mem_done = 0; step(1);

      // Randomized traffic with occasional aborts, stray mem_done and resets.
      for (int i = 0; i < 4000; i++) begin
         rst      = ($urandom_range(0, 199) == 0);
         mem_done = ($urandom_range(0, 2) == 0);
         if (!(c0_rd | c0_wr)) begin
            if ($urandom_range(0, 2) == 0) begin
               kind = 2'($urandom_range(1, 3));
               c0_rd = kind[0]; c0_wr = kind[1];
               c0_addr = 5'($urandom_range(0, 7)); c0_din = 16'($urandom);
            end
         end else if ($urandom_range(0, 39) == 0) begin
            c0_rd = 0; c0_wr = 0;
         end
         if (!(c1_rd | c1_wr)) begin
            if ($urandom_range(0, 2) == 0) begin
               kind = 2'($urandom_range(1, 3));
               c1_rd = kind[0]; c1_wr = kind[1];
               c1_addr = 5'($urandom_range(0, 7)); c1_din = 16'($urandom);
            end
         end else if ($urandom_range(0, 39) == 0) begin
            c1_rd = 0; c1_wr = 0;
         end
         step(1);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, memory word width.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports c0_rd, c0_wr  input  1 each  port-0 (instruction cache) read and write requests.
REQ-006 SHALL have port c0_addr  input  ADDR_W  port-0 word address.
REQ-007 SHALL have port c0_din  input  DATA_W  port-0 write data.
REQ-008 SHALL have ports c1_rd, c1_wr, c1_addr, c1_din, which mirror the port-0 inputs for port 1 (data cache).
REQ-009 SHALL have ports c0_dout, c1_dout  output  DATA_W each  read data; both are driven with mem_dout at all times.
REQ-010 SHALL have ports c0_done, c1_done  output  1 each  transaction-complete pulses.
REQ-011 SHALL have ports mem_addr, mem_din, mem_rd, mem_wr  output  ADDR_W/DATA_W/1/1  drive the shared Memory.
REQ-012 SHALL have ports mem_dout, mem_done  input  DATA_W/1  Memory read data and completion strobe.
REQ-013 SHALL have port grant  output  2  one-hot owner (01 = port 0, 10 = port 1, 00 = none).
REQ-014 SHALL have ports c0_cnt, c1_cnt  output  8 each  count of completed transactions per port.

Function
REQ-015 SHALL implement a one-hot FSM with states IDLE=3'b001, BUSY0=3'b010, BUSY1=3'b100.
REQ-016 SHALL treat port x as requesting when cx_rd|cx_wr is 1; if both cx_rd and cx_wr are 1, the request SHALL be a write and mem_rd SHALL be 0.
REQ-017 In IDLE with exactly one port requesting, the FSM SHALL move to that port's BUSY state on the next edge.
REQ-018 In IDLE with both ports requesting, the FSM SHALL grant the port not recorded in the 1-bit register last (round-robin).
REQ-019 In IDLE, mem_rd, mem_wr and grant SHALL be 0; mem_addr and mem_din SHALL be 0.
REQ-020 In BUSYx, mem_addr, mem_din, mem_rd and mem_wr SHALL combinationally follow port x's inputs; grant[x] SHALL be 1.
REQ-021 In BUSYx with mem_done=1, cx_done SHALL be 1 in that same cycle; on the next edge the FSM SHALL go to IDLE, last SHALL be set to x, and cx_cnt SHALL increment.
REQ-022 cx_cnt SHALL wrap from 255 to 0.
REQ-023 The other port's done output SHALL be 0 throughout.
REQ-024 In BUSYx with port x's request low and mem_done=0 (abort), the FSM SHALL go to IDLE on the next edge with no done pulse, no count, and last unchanged.
REQ-025 Every grant SHALL pass through at least one IDLE cycle, so Memory sees mem_rd/mem_wr low for at least one cycle between transactions.
REQ-026 mem_done=1 while in IDLE SHALL be ignored.
REQ-027 A requester SHALL hold its request stable until its done pulse; the arbiter SHALL NOT latch requester inputs.
REQ-028 Latency from a request in IDLE to mem_rd/mem_wr high SHALL be 1 cycle.
REQ-029 The losing port in a tie SHALL be served by the next grant if it is still requesting, so a continuously requesting port waits at most one transaction.

Reset
REQ-030 On an edge with rst=1: state SHALL become IDLE, last SHALL become 1 (port 0 wins the first tie), and c0_cnt and c1_cnt SHALL become 0.
REQ-031 c0_done and c1_done SHALL be forced to 0 combinationally while rst=1.
REQ-032 Reset asserted mid-transaction SHALL drop mem_rd/mem_wr from the reset edge onward, with no done pulse and no count increment.

Verification
REQ-033 After reset, c0_wr=1, c0_addr=4, c0_din=16'h0C03 -> mem_wr high 1 cycle later; c0_done with mem_done; c0_cnt=1.
REQ-034 Following REQ-033, c1_rd=1, c1_addr=4 -> c1_done pulse with c1_dout=16'h0C03; c1_cnt=1; grant=10 during the transaction.
REQ-035 Both ports request in the same cycle after reset -> port 0 served first, then IDLE, then port 1; the next tie with last=1 -> port 0 served first.
REQ-036 Port 0 issues 256 back-to-back reads -> c0_cnt=0 after wrap; c1_cnt unchanged; mem_rd low at least 1 cycle between reads.
REQ-037 rst pulsed for 1 cycle during BUSY1 before mem_done -> state IDLE, mem_rd=0, c1_done never asserted, counters 0.
REQ-038 c0_rd dropped in BUSY0 before mem_done -> IDLE next cycle, no c0_done, c0_cnt unchanged, a pending port-1 request then granted.
